// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
// Module : collatz_pkg
// Brief  : Shared widths and sweep-sequencer state encoding.
// Rev    : 1.0
// ============================================================================
package collatz_pkg;

    localparam int SEED_W  = 8;
    localparam int K_W     = 20;
    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] S_LOAD  = 4'd1;
    localparam logic [STATE_W-1:0] S_START = 4'd2;
    localparam logic [STATE_W-1:0] S_ACK   = 4'd3;
    localparam logic [STATE_W-1:0] S_RUN   = 4'd4;
    localparam logic [STATE_W-1:0] S_CMP   = 4'd5;
    localparam logic [STATE_W-1:0] S_NEXT  = 4'd6;
    localparam logic [STATE_W-1:0] S_DONE  = 4'd7;
    localparam logic [STATE_W-1:0] S_ERR   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/collatz_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : collatz_sweep_ctrl_if
// Brief  : Start/busy handshake between the sweep sequencer and one core.
// Rev    : 1.0
// ============================================================================
interface collatz_sweep_ctrl_if;

    logic [collatz_pkg::SEED_W-1:0] core_co;
    logic                           core_st;
    logic                           core_bs;
    logic [collatz_pkg::K_W-1:0]    core_k;

    modport master (output core_co, output core_st, input core_bs, input core_k);
    modport slave  (input core_co, input core_st, output core_bs, output core_k);

endinterface
`default_nettype wire

// File: rtl/collatz_watchdog.sv
`default_nettype none
// ============================================================================
// Module : collatz_watchdog
// Brief  : Loadable down-counter; expired is high while the count is zero.
// Rev    : 1.0
// ============================================================================
module collatz_watchdog #(
    parameter int CNT_W = 20
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/collatz_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : collatz_sweep_ctrl
// Brief  : Walks one Collatz core over [seed_lo, seed_hi], keeps the longest.
// Rev    : 1.0
// ============================================================================
module collatz_sweep_ctrl
    import collatz_pkg::*;
#(
    parameter int ACK_TMO = 4,
    parameter int RUN_TMO = 1048575
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              go,
    input  wire logic [SEED_W-1:0] seed_lo,
    input  wire logic [SEED_W-1:0] seed_hi,
    collatz_sweep_ctrl_if.master   core,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [SEED_W-1:0]      cur_seed,
    output logic [SEED_W-1:0]      best_seed,
    output logic [K_W-1:0]         best_steps
);

    localparam int c_wd_max = (ACK_TMO > RUN_TMO) ? ACK_TMO : RUN_TMO;
    localparam int c_wd_w   = $clog2(c_wd_max + 1);
    // Loaded with TMO-1 so the timeout fires on the TMO-th waiting cycle.
    localparam logic [c_wd_w-1:0] c_ack_load = c_wd_w'(ACK_TMO - 1);
    localparam logic [c_wd_w-1:0] c_run_load = c_wd_w'(RUN_TMO - 1);

    logic [STATE_W-1:0] r_state;
    logic [SEED_W-1:0]  r_seed;
    logic [SEED_W-1:0]  r_hi;
    logic [SEED_W-1:0]  r_cur;
    logic [SEED_W-1:0]  r_co;
    logic [SEED_W-1:0]  r_best_seed;
    logic [K_W-1:0]     r_best_steps;
    logic               r_st;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_wd_load;
    logic [c_wd_w-1:0]  w_wd_val;
    logic               w_wd_dec;
    logic               w_wd_exp;

    always_comb begin
        w_wd_load = 1'b0;
        w_wd_val  = c_ack_load;
        w_wd_dec  = 1'b0;
        if (r_state == S_START) begin
            w_wd_load = 1'b1;
        end else if (r_state == S_ACK) begin
            w_wd_load = core.core_bs;
            w_wd_val  = c_run_load;
            w_wd_dec  = !core.core_bs;
        end else if (r_state == S_RUN) begin
            w_wd_dec  = core.core_bs;
        end
    end

    collatz_watchdog #(
        .CNT_W (c_wd_w)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_wd_load),
        .load_val (w_wd_val),
        .dec      (w_wd_dec),
        .expired  (w_wd_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_seed       <= '0;
            r_hi         <= '0;
            r_cur        <= '0;
            r_co         <= '0;
            r_best_seed  <= '0;
            r_best_steps <= '0;
            r_st         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_st   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (go) begin
                        r_seed       <= seed_lo;
                        r_hi         <= seed_hi;
                        r_best_seed  <= '0;
                        r_best_steps <= '0;
                        r_err        <= 1'b0;
                        // An empty range finishes without ever touching the core.
                        if (seed_lo > seed_hi) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_cur <= r_seed;
                    r_co  <= r_seed;
                    if (r_seed == '0) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_st    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: r_state <= S_ACK;
                S_ACK: begin
                    if (core.core_bs) begin
                        r_state <= S_RUN;
                    end else if (w_wd_exp) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_RUN: begin
                    if (!core.core_bs) begin
                        r_state <= S_CMP;
                    end else if (w_wd_exp) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_CMP: begin
                    if (core.core_k > r_best_steps) begin
                        r_best_seed  <= r_seed;
                        r_best_steps <= core.core_k;
                    end
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    // Compare before incrementing so seed_hi=255 never wraps.
                    if (r_seed == r_hi) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_seed  <= r_seed + SEED_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core.core_co = r_co;
    assign core.core_st = r_st;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign cur_seed     = r_cur;
    assign best_seed    = r_best_seed;
    assign best_steps   = r_best_steps;

endmodule
`default_nettype wire

// File: tb/tb_collatz_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_collatz_sweep_ctrl
// Brief  : Self-checking bench with a behavioural Collatz core and sweep model.
// Rev    : 1.0
// ============================================================================
module tb_collatz_sweep_ctrl;
    import collatz_pkg::*;

    localparam int ACK_TMO = 4;
    localparam int BUDGET  = 20000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic [SEED_W-1:0] seed_lo = '0;
    logic [SEED_W-1:0] seed_hi = '0;
    logic              busy, done, err;
    logic [SEED_W-1:0] cur_seed, best_seed;
    logic [K_W-1:0]    best_steps;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int st_cnt = 0;
    bit core_dead = 1'b0;

    collatz_sweep_ctrl_if cif ();

    collatz_sweep_ctrl #(
        .ACK_TMO (ACK_TMO),
        .RUN_TMO (1048575)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .seed_lo    (seed_lo),
        .seed_hi    (seed_hi),
        .core       (cif.master),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_seed   (cur_seed),
        .best_seed  (best_seed),
        .best_steps (best_steps)
    );

    always #5 clk = ~clk;

    function automatic int steps_of(input int seed);
        int n = seed;
        int s = 0;
        while (n > 1) begin
            n = (n % 2 == 1) ? 3 * n + 1 : n / 2;
            s++;
        end
        return s;
    endfunction

    // Behavioural core: 3 cycles per step, random 0..2 cycle start latency.
    bit pend = 1'b0;
    int cw = 0;
    int cr = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cif.core_bs <= 1'b0;
            cif.core_k  <= '0;
            pend <= 1'b0;
            cw   <= 0;
            cr   <= 0;
        end else if (cif.core_bs) begin
            if (cr <= 1) cif.core_bs <= 1'b0;
            cr <= cr - 1;
        end else if (pend) begin
            if (cw == 0) begin
                cif.core_bs <= 1'b1;
                pend <= 1'b0;
            end else begin
                cw <= cw - 1;
            end
        end else if (cif.core_st && !core_dead) begin
            pend       <= 1'b1;
            cw         <= int'($urandom_range(0, 2));
            cif.core_k <= K_W'(steps_of(int'(cif.core_co)));
            cr         <= (steps_of(int'(cif.core_co)) == 0) ? 1 : 3 * steps_of(int'(cif.core_co));
        end
    end

    always @(negedge clk) begin
        if (rst_n && done)        done_cnt <= done_cnt + 1;
        if (rst_n && cif.core_st) st_cnt   <= st_cnt + 1;
    end

    task automatic start(input int lo, input int hi);
        @(negedge clk);
        go = 1'b1;
        seed_lo = SEED_W'(lo);
        seed_hi = SEED_W'(hi);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(output bit timed_out);
        int n;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (done || err) break;
        end
        timed_out = (n == BUDGET);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (err !== 1'b0)         begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
        n_cmp++; if (cif.core_st !== 1'b0) begin n_bad++; $display("FAIL reset_core_st got %0b want 0", cif.core_st); end
        n_cmp++; if (cif.core_co !== '0)   begin n_bad++; $display("FAIL reset_core_co got %0d want 0", cif.core_co); end
        n_cmp++; if (cur_seed !== '0)      begin n_bad++; $display("FAIL reset_cur_seed got %0d want 0", cur_seed); end
        n_cmp++; if (best_seed !== '0)     begin n_bad++; $display("FAIL reset_best_seed got %0d want 0", best_seed); end
        n_cmp++; if (best_steps !== '0)    begin n_bad++; $display("FAIL reset_best_steps got %0d want 0", best_steps); end
    endtask

    task automatic test_range(input int lo, input int hi, input string tag);
        int best_s = 0;
        int best_k = 0;
        int n_st = 0;
        int d0, s0;
        bit to;
        for (int s = lo; s <= hi; s++) begin
            if (s != 0) begin
                n_st++;
                if (steps_of(s) > best_k) begin
                    best_k = steps_of(s);
                    best_s = s;
                end
            end
        end
        d0 = done_cnt;
        s0 = st_cnt;
        start(lo, hi);
        wait_end(to);
        n_cmp++; if (to)                    begin n_bad++; $display("FAIL %s_timeout no done/err within %0d cycles", tag, BUDGET); end
        n_cmp++; if (done_cnt - d0 != 1)    begin n_bad++; $display("FAIL %s_done_pulses got %0d want 1", tag, done_cnt - d0); end
        n_cmp++; if (st_cnt - s0 != n_st)   begin n_bad++; $display("FAIL %s_core_st_pulses got %0d want %0d", tag, st_cnt - s0, n_st); end
        n_cmp++; if (best_seed !== SEED_W'(best_s)) begin n_bad++; $display("FAIL %s_best_seed got %0d want %0d", tag, best_seed, best_s); end
        n_cmp++; if (best_steps !== K_W'(best_k))   begin n_bad++; $display("FAIL %s_best_steps got %0d want %0d", tag, best_steps, best_k); end
        n_cmp++; if (err !== 1'b0)          begin n_bad++; $display("FAIL %s_err got %0b want 0", tag, err); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL %s_busy got %0b want 0", tag, busy); end
        n_cmp++; if (cur_seed !== SEED_W'(hi)) begin n_bad++; $display("FAIL %s_cur_seed got %0d want %0d", tag, cur_seed, hi); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            int lo = int'($urandom_range(0, 255));
            int hi = lo + int'($urandom_range(0, 6));
            if (hi > 255) hi = 255;
            test_range(lo, hi, "random");
        end
    endtask

    task automatic test_go_while_busy();
        int d0 = done_cnt;
        int s0 = st_cnt;
        bit to;
        start(1, 3);
        repeat (5) @(negedge clk);
        go = 1'b1; seed_lo = 8'd100; seed_hi = 8'd100;
        @(negedge clk);
        go = 1'b0;
        wait_end(to);
        n_cmp++; if (to || done_cnt - d0 != 1) begin n_bad++; $display("FAIL busy_go_done got %0d want 1", done_cnt - d0); end
        n_cmp++; if (st_cnt - s0 != 3)        begin n_bad++; $display("FAIL busy_go_st got %0d want 3", st_cnt - s0); end
        n_cmp++; if (best_seed !== 8'd3 || best_steps !== K_W'(7)) begin
            n_bad++; $display("FAIL busy_go_best got %0d/%0d want 3/7", best_seed, best_steps);
        end
    endtask

    task automatic test_empty();
        int s0 = st_cnt;
        start(20, 5);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done got %0b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy got %0b want 0", busy); end
        n_cmp++; if (best_seed !== '0 || best_steps !== '0) begin
            n_bad++; $display("FAIL empty_best got %0d/%0d want 0/0", best_seed, best_steps);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (st_cnt != s0 || err !== 1'b0) begin
            n_bad++; $display("FAIL empty_no_core got st %0d err %0b want 0/0", st_cnt - s0, err);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int n;
        bit to;
        core_dead = 1'b1;
        start(5, 5);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (err) break;
        end
        n_cmp++; if (n < ACK_TMO || n > ACK_TMO + 3) begin
            n_bad++; $display("FAIL tmo_latency got %0d cycles want %0d..%0d", n, ACK_TMO, ACK_TMO + 3);
        end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1)          begin n_bad++; $display("FAIL tmo_err got %0b want 1", err); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL tmo_busy got %0b want 0", busy); end
        n_cmp++; if (done_cnt != d0)        begin n_bad++; $display("FAIL tmo_done got %0d pulses want 0", done_cnt - d0); end
        n_cmp++; if (cif.core_st !== 1'b0)  begin n_bad++; $display("FAIL tmo_core_st got %0b want 0", cif.core_st); end
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b1)          begin n_bad++; $display("FAIL tmo_sticky got %0b want 1", err); end
        core_dead = 1'b0;
        start(3, 3);
        n_cmp++; if (err !== 1'b0)          begin n_bad++; $display("FAIL tmo_clear got %0b want 0", err); end
        wait_end(to);
        n_cmp++; if (to || best_seed !== 8'd3 || best_steps !== K_W'(7)) begin
            n_bad++; $display("FAIL tmo_restart got %0d/%0d want 3/7", best_seed, best_steps);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start(27, 27);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cif.core_bs) break;
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_running got busy %0b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cif.core_st !== 1'b0 || cif.core_co !== '0) begin
            n_bad++; $display("FAIL rstmid_ctl got busy %0b done %0b err %0b st %0b co %0d want all 0",
                              busy, done, err, cif.core_st, cif.core_co);
        end
        n_cmp++; if (cur_seed !== '0 || best_seed !== '0 || best_steps !== '0) begin
            n_bad++; $display("FAIL rstmid_data got %0d/%0d/%0d want 0/0/0", cur_seed, best_seed, best_steps);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        test_range(1, 4, "post_reset");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        #2 rst_n = 1'b1;
        test_range(1, 10, "r1_10");
        test_range(27, 27, "r27");
        test_range(0, 2, "r0_2");
        test_range(250, 255, "r250_255");
        test_random();
        test_go_while_busy();
        test_empty();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
